// File: rtl/adc_sar_pkg.sv
// adc_sar_pkg: shared SAR ADC constants and controller state encoding
// Used by adc_sar_ctrl and adc_row_col_decoder (ADC_BITS).
package adc_sar_pkg;
    localparam int ADC_BITS = 12;
    localparam logic [ADC_BITS-1:0] MIDSCALE = 12'h800;
    localparam logic [3:0] MSB_IDX = 4'(ADC_BITS - 1);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_t;
endpackage

// File: rtl/adc_sar_timer.sv
// adc_sar_timer: loadable down-counter timing the SAMPLE and SETTLE intervals
// Ports: clk, rst_n (async active-low), load/load_val (start an interval of
// load_val cycles), done (high in the last cycle of the interval).
module adc_sar_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;
    // Loaded on the edge entering an interval, so cnt==1 marks its final cycle;
    // the count parks at zero rather than wrapping.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - W'(1);
    assign done = (cnt == W'(1));
endmodule

// File: rtl/adc_sar_ctrl.sv
// adc_sar_ctrl: successive-approximation controller producing the 12-bit DAC trial code
// Ports: clk, rst_n (async active-low), start (conversion request), comp_in
// (comparator, 1 = Vin >= DAC), dac_data (trial code), sample, comp_strobe,
// busy, result (last conversion), result_valid (one-cycle pulse in DONE).
module adc_sar_ctrl
    import adc_sar_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                comp_in,
    output logic [ADC_BITS-1:0] dac_data,
    output logic                sample,
    output logic                comp_strobe,
    output logic                busy,
    output logic [ADC_BITS-1:0] result,
    output logic                result_valid
);
    localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CW = $clog2(CMAX + 1);

    state_t              state, nxt;
    logic                tmr_load, tmr_done;
    logic [CW-1:0]       tmr_val;
    logic [3:0]          bit_idx;
    logic [ADC_BITS-1:0] kept;

    adc_sar_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:    nxt = start ? ST_SAMPLE : ST_IDLE;
            ST_SAMPLE:  nxt = tmr_done ? ST_SETTLE : ST_SAMPLE;
            ST_SETTLE:  nxt = tmr_done ? ST_COMPARE : ST_SETTLE;
            ST_COMPARE: nxt = (bit_idx == '0) ? ST_DONE : ST_SETTLE;
            ST_DONE:    nxt = start ? ST_SAMPLE : ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
        // The timer is reloaded only on entry, so a state's interval restarts each visit.
        tmr_load     = (nxt != state) && (nxt == ST_SAMPLE || nxt == ST_SETTLE);
        tmr_val      = (nxt == ST_SAMPLE) ? CW'(SAMPLE_CYCLES) : CW'(SETTLE_CYCLES);
        kept         = comp_in ? dac_data : (dac_data & ~(ADC_BITS'(1) << bit_idx));
        sample       = (state == ST_SAMPLE);
        comp_strobe  = (state == ST_COMPARE);
        busy         = (state != ST_IDLE);
        result_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= ST_IDLE;
            dac_data <= '0;
            bit_idx  <= '0;
            result   <= '0;
        end else begin
            state <= nxt;
            if (state != ST_SAMPLE && nxt == ST_SAMPLE)
                dac_data <= '0;
            else if (state == ST_SAMPLE && nxt == ST_SETTLE) begin
                dac_data <= MIDSCALE;
                bit_idx  <= MSB_IDX;
            end else if (state == ST_COMPARE) begin
                if (bit_idx == '0) begin
                    dac_data <= kept;
                    result   <= kept;
                end else begin
                    dac_data <= kept | (ADC_BITS'(1) << (bit_idx - 4'd1));
                    bit_idx  <= bit_idx - 4'd1;
                end
            end
        end
endmodule

// File: tb/tb_adc_sar_ctrl.sv
// tb_adc_sar_ctrl: randomized self-checking bench for adc_sar_ctrl against an ideal-comparator SAR model
module tb_adc_sar_ctrl;
    localparam int LAT_A = 4 + 12 * (2 + 1) + 1;
    localparam int LAT_B = 1 + 12 * (1 + 1) + 1;

    logic clk = 0, rst_n = 0, start_a = 0, start_b = 0, noise = 0;
    logic [11:0] vin_a = 0, vin_b = 0;
    logic comp_a, comp_b;
    logic [11:0] a_dac, a_result, b_dac, b_result;
    logic a_sample, a_strobe, a_busy, a_valid, b_sample, b_strobe, b_busy, b_valid;
    int checks = 0, passed = 0;
    int ns_a = 0, nv_a = 0, ns_b = 0, nv_b = 0;
    logic [11:0] tr_a[$], tr_b[$];

    always #5 clk = ~clk;

    adc_sar_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .comp_in(comp_a),
        .dac_data(a_dac), .sample(a_sample), .comp_strobe(a_strobe),
        .busy(a_busy), .result(a_result), .result_valid(a_valid)
    );

    adc_sar_ctrl #(.SAMPLE_CYCLES(1), .SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .comp_in(comp_b),
        .dac_data(b_dac), .sample(b_sample), .comp_strobe(b_strobe),
        .busy(b_busy), .result(b_result), .result_valid(b_valid)
    );

    // Ideal comparator while strobed; random garbage otherwise, since comp_in is don't-care then.
    always @(negedge clk) noise <= 1'($urandom_range(0, 1));
    assign comp_a = a_strobe ? (vin_a >= a_dac) : noise;
    assign comp_b = b_strobe ? (vin_b >= b_dac) : noise;

    always @(posedge clk) begin
        #1;
        if (a_strobe) begin tr_a.push_back(a_dac); ns_a++; end
        if (b_strobe) begin tr_b.push_back(b_dac); ns_b++; end
        if (a_valid) nv_a++;
        if (b_valid) nv_b++;
    end

    // Binary search: bits above b already equal Vin's, bit b tried as 1, bits below 0.
    function automatic logic [11:0] model_trial(input logic [11:0] v, input int b);
        return 12'(((int'(v) >> (b + 1)) << (b + 1)) | (1 << b));
    endfunction

    task automatic conv(input bit sel, input logic [11:0] v, input bit hold,
                        output logic [11:0] res, output int lat);
        if (sel) begin vin_b = v; tr_b.delete(); ns_b = 0; nv_b = 0; start_b = 1; end
        else begin vin_a = v; tr_a.delete(); ns_a = 0; nv_a = 0; start_a = 1; end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!hold) begin start_a = 0; start_b = 0; end
        end while (!(sel ? b_valid : a_valid) && lat < 300);
        res = sel ? b_result : a_result;
        if (lat >= 300) begin
            checks++;
            $display("FAIL conv_timeout sel=%0d: waited %0d cycles, required result_valid", sel, lat);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if ({a_dac, a_result, a_sample, a_strobe, a_busy, a_valid} !== 28'h0)
            $display("FAIL reset_a: got %h want 0", {a_dac, a_result, a_sample, a_strobe, a_busy, a_valid}); else passed++;
        checks++; if ({b_dac, b_result, b_sample, b_strobe, b_busy, b_valid} !== 28'h0)
            $display("FAIL reset_b: got %h want 0", {b_dac, b_result, b_sample, b_strobe, b_busy, b_valid}); else passed++;
        rst_n = 1;
        repeat (3) @(negedge clk);
        checks++; if (a_busy !== 1'b0) $display("FAIL idle_after_reset: busy got %b want 0", a_busy); else passed++;
    endtask

    task automatic test_zero;
        logic [11:0] res; int lat;
        logic [11:0] exp3[3] = '{12'h800, 12'h400, 12'h200};
        conv(0, 12'h000, 0, res, lat);
        checks++; if (res !== 12'h000) $display("FAIL zero_result: got %h want 000", res); else passed++;
        checks++; if (lat !== LAT_A) $display("FAIL zero_latency: got %0d want %0d", lat, LAT_A); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (tr_a[i] !== exp3[i]) $display("FAIL zero_trial%0d: got %h want %h", i, tr_a[i], exp3[i]); else passed++;
        end
        checks++; if (ns_a !== 12) $display("FAIL zero_strobes: got %0d want 12", ns_a); else passed++;
    endtask

    task automatic test_full;
        logic [11:0] res; int lat;
        conv(0, 12'hFFF, 0, res, lat);
        checks++; if (res !== 12'hFFF) $display("FAIL full_result: got %h want FFF", res); else passed++;
        for (int i = 0; i < 12; i++) begin
            checks++; if (tr_a[i] !== model_trial(12'hFFF, 11 - i))
                $display("FAIL full_trial%0d: got %h want %h", i, tr_a[i], model_trial(12'hFFF, 11 - i)); else passed++;
        end
        @(negedge clk);
        checks++; if (a_valid !== 1'b0 || nv_a !== 1) $display("FAIL full_pulse: valid %b pulses %0d want 0/1", a_valid, nv_a); else passed++;
        checks++; if (a_busy !== 1'b0) $display("FAIL full_idle: busy got %b want 0", a_busy); else passed++;
        checks++; if (a_dac !== 12'hFFF) $display("FAIL full_dac_hold: got %h want FFF", a_dac); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [11:0] res; int lat;
        conv(0, 12'h5A5, 1, res, lat);
        checks++; if (res !== 12'h5A5) $display("FAIL b2b_first: got %h want 5A5", res); else passed++;
        vin_a = 12'h123; tr_a.delete(); ns_a = 0; nv_a = 0;
        @(negedge clk);
        checks++; if (a_sample !== 1'b1 || a_busy !== 1'b1)
            $display("FAIL b2b_no_idle: sample %b busy %b want 1/1", a_sample, a_busy); else passed++;
        start_a = 0;
        lat = 1;
        while (!a_valid && lat < 300) begin @(negedge clk); lat++; end
        checks++; if (a_result !== 12'h123) $display("FAIL b2b_second: got %h want 123", a_result); else passed++;
        checks++; if (lat !== LAT_A) $display("FAIL b2b_latency: got %0d want %0d", lat, LAT_A); else passed++;
    endtask

    task automatic test_start_ignored;
        int lat = 1; bit dropped = 0;
        vin_a = 12'h800; tr_a.delete(); ns_a = 0; nv_a = 0;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        while (!a_valid && lat < 300) begin
            if (!a_busy) dropped = 1;
            start_a = (a_busy && !a_sample) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            lat++;
        end
        start_a = 0;
        repeat (4) @(negedge clk);
        checks++; if (nv_a !== 1) $display("FAIL ign_pulses: got %0d want 1", nv_a); else passed++;
        checks++; if (a_result !== 12'h800) $display("FAIL ign_result: got %h want 800", a_result); else passed++;
        checks++; if (dropped !== 1'b0) $display("FAIL ign_busy: busy dropped early"); else passed++;
        checks++; if (lat !== LAT_A) $display("FAIL ign_latency: got %0d want %0d", lat, LAT_A); else passed++;
        checks++; if (a_busy !== 1'b0) $display("FAIL ign_idle: busy got %b want 0", a_busy); else passed++;
    endtask

    task automatic test_reset_mid;
        logic [11:0] res; int lat, n = 0;
        vin_a = 12'($urandom); tr_a.delete(); ns_a = 0; nv_a = 0;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        while (ns_a < 6 && n < 300) begin @(negedge clk); n++; end
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++; if (a_dac !== 12'h0) $display("FAIL rst_dac: got %h want 0", a_dac); else passed++;
        checks++; if (a_result !== 12'h0) $display("FAIL rst_result: got %h want 0", a_result); else passed++;
        checks++; if ({a_sample, a_strobe, a_busy, a_valid} !== 4'h0)
            $display("FAIL rst_flags: got %b want 0000", {a_sample, a_strobe, a_busy, a_valid}); else passed++;
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        checks++; if (a_busy !== 1'b0) $display("FAIL rst_wait_idle: busy got %b want 0", a_busy); else passed++;
        conv(0, 12'h0F0, 0, res, lat);
        checks++; if (res !== 12'h0F0) $display("FAIL rst_fresh: got %h want 0F0", res); else passed++;
        checks++; if (lat !== LAT_A) $display("FAIL rst_fresh_lat: got %0d want %0d", lat, LAT_A); else passed++;
    endtask

    task automatic test_small;
        logic [11:0] res; int lat;
        conv(1, 12'hAAA, 0, res, lat);
        checks++; if (res !== 12'hAAA) $display("FAIL small_result: got %h want AAA", res); else passed++;
        checks++; if (lat !== LAT_B) $display("FAIL small_latency: got %0d want %0d", lat, LAT_B); else passed++;
        @(negedge clk);
        checks++; if (ns_b !== 12) $display("FAIL small_strobes: got %0d want 12", ns_b); else passed++;
        checks++; if (nv_b !== 1 || b_busy !== 1'b0) $display("FAIL small_done: pulses %0d busy %b want 1/0", nv_b, b_busy); else passed++;
    endtask

    task automatic test_random;
        logic [11:0] res, v; int lat;
        for (int k = 0; k < 10; k++) begin
            bit sel = (k >= 6);
            v = 12'($urandom);
            conv(sel, v, 0, res, lat);
            checks++; if (res !== v) $display("FAIL rand_result%0d: got %h want %h", k, res, v); else passed++;
            checks++; if (lat !== (sel ? LAT_B : LAT_A)) $display("FAIL rand_latency%0d: got %0d want %0d", k, lat, sel ? LAT_B : LAT_A); else passed++;
            for (int i = 0; i < 12; i++) begin
                logic [11:0] got = sel ? tr_b[i] : tr_a[i];
                checks++; if (got !== model_trial(v, 11 - i))
                    $display("FAIL rand_trial%0d_%0d: got %h want %h", k, i, got, model_trial(v, 11 - i)); else passed++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero();
        test_full();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_small();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
